// File: rtl/alu_share_arbiter.sv
// Round-robin share of one ALUwhole between two requesters: latch the winner's
// operands, hold them on the ALU for ALU_LAT cycles, capture the result, pulse done.
//
// state | meaning
// IDLE  | no operation in flight; requests sampled here
// EXEC  | winner granted, operands held on the ALU, latency timer running
// DONE  | result captured, done pulse to the winner, back to IDLE next edge
module alu_share_arbiter #(
  parameter int WIDTH   = 32,
  parameter int ALU_LAT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic             req1,
  input  logic [1:0]       alu_op0,
  input  logic [1:0]       alu_op1,
  input  logic [5:0]       fuc0,
  input  logic [5:0]       fuc1,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b0,
  input  logic [WIDTH-1:0] b1,
  output logic             grant0,
  output logic             grant1,
  output logic             done0,
  output logic             done1,
  output logic [WIDTH-1:0] res_data,
  output logic             res_zero,
  output logic             res_carry,
  output logic             res_ovf,
  output logic             busy,
  output logic [1:0]       ALUop,
  output logic [5:0]       Fuc,
  output logic [WIDTH-1:0] Adat,
  output logic [WIDTH-1:0] Bdat,
  input  logic [WIDTH-1:0] Result,
  input  logic             zero,
  input  logic             carryout,
  input  logic             overflow
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [2:0] LAT_LOAD = 3'(ALU_LAT - 1);

  state_t           state;
  logic [2:0]       cnt;
  logic             ptr;
  logic             win;

  logic             any_req;
  logic             pick1;
  logic [1:0]       sel_op;
  logic [5:0]       sel_fuc;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;

  // A lone requester wins outright; a tie goes to whichever side ptr favours.
  always_comb begin
    any_req = req0 | req1;
    pick1   = req1 & (~req0 | ptr);
    sel_op  = pick1 ? alu_op1 : alu_op0;
    sel_fuc = pick1 ? fuc1    : fuc0;
    sel_a   = pick1 ? a1      : a0;
    sel_b   = pick1 ? b1      : b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      ptr       <= 1'b0;
      win       <= 1'b0;
      grant0    <= 1'b0;
      grant1    <= 1'b0;
      done0     <= 1'b0;
      done1     <= 1'b0;
      busy      <= 1'b0;
      ALUop     <= '0;
      Fuc       <= '0;
      Adat      <= '0;
      Bdat      <= '0;
      res_data  <= '0;
      res_zero  <= 1'b0;
      res_carry <= 1'b0;
      res_ovf   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (any_req) begin
            state  <= S_EXEC;
            win    <= pick1;
            ptr    <= ~pick1;
            cnt    <= LAT_LOAD;
            grant0 <= ~pick1;
            grant1 <= pick1;
            busy   <= 1'b1;
            ALUop  <= sel_op;
            Fuc    <= sel_fuc;
            Adat   <= sel_a;
            Bdat   <= sel_b;
          end
        end
        // Timer counts down; terminal count is the edge ALU_LAT cycles after grant.
        S_EXEC: begin
          if (cnt == 3'd0) begin
            state     <= S_DONE;
            res_data  <= Result;
            res_zero  <= zero;
            res_carry <= carryout;
            res_ovf   <= overflow;
            done0     <= ~win;
            done1     <= win;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        // ALU ports deliberately keep their values on the way back to IDLE.
        S_DONE: begin
          state  <= S_IDLE;
          grant0 <= 1'b0;
          grant1 <= 1'b0;
          done0  <= 1'b0;
          done1  <= 1'b0;
          busy   <= 1'b0;
        end
        default: begin
          state  <= S_IDLE;
          grant0 <= 1'b0;
          grant1 <= 1'b0;
          done0  <= 1'b0;
          done1  <= 1'b0;
          busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with ALU_LAT=3 and an adder standing in
// for ALUwhole; expected values are hand-computed constants.
module tb_alu_share_arbiter;

  localparam int W   = 32;
  localparam int LAT = 3;

  logic         clk = 1'b0;
  logic         rst;
  logic         req0, req1;
  logic [1:0]   alu_op0, alu_op1;
  logic [5:0]   fuc0, fuc1;
  logic [W-1:0] a0, a1, b0, b1;
  logic         grant0, grant1, done0, done1;
  logic [W-1:0] res_data;
  logic         res_zero, res_carry, res_ovf, busy;
  logic [1:0]   ALUop;
  logic [5:0]   Fuc;
  logic [W-1:0] Adat, Bdat;
  logic [W-1:0] Result;
  logic         zero, carryout, overflow;
  logic [W:0]   sum;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  assign sum      = {1'b0, Adat} + {1'b0, Bdat};
  assign Result   = sum[W-1:0];
  assign zero     = (sum[W-1:0] == '0);
  assign carryout = sum[W];
  assign overflow = (Adat[W-1] == Bdat[W-1]) && (sum[W-1] != Adat[W-1]);

  alu_share_arbiter #(.WIDTH(W), .ALU_LAT(LAT)) dut (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1),
    .alu_op0(alu_op0), .alu_op1(alu_op1), .fuc0(fuc0), .fuc1(fuc1),
    .a0(a0), .a1(a1), .b0(b0), .b1(b1),
    .grant0(grant0), .grant1(grant1), .done0(done0), .done1(done1),
    .res_data(res_data), .res_zero(res_zero), .res_carry(res_carry), .res_ovf(res_ovf),
    .busy(busy), .ALUop(ALUop), .Fuc(Fuc), .Adat(Adat), .Bdat(Bdat),
    .Result(Result), .zero(zero), .carryout(carryout), .overflow(overflow)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Ticks until the selected done is seen (bounded) and checks how many ticks it took.
  task automatic wait_done(input bit which, input int exp_ticks, input string tag);
    int k = 0;
    do begin
      tick();
      k++;
    end while (!(which ? done1 : done0) && k < 20);
    chk({tag, "_latency"}, 64'(k), 64'(exp_ticks));
  endtask

  initial begin
    rst = 1'b1; req0 = 0; req1 = 0;
    alu_op0 = 2'b11; alu_op1 = 2'b10; fuc0 = 6'h3f; fuc1 = 6'h15;
    a0 = 32'h1234; b0 = 32'h5678; a1 = 32'h9abc; b1 = 32'hdef0;

    // T1 reset
    tick(); tick();
    chk("rst_busy", busy, 0);
    chk("rst_grant0", grant0, 0);
    chk("rst_grant1", grant1, 0);
    chk("rst_done0", done0, 0);
    chk("rst_done1", done1, 0);
    chk("rst_aluop", ALUop, 0);
    chk("rst_fuc", Fuc, 0);
    chk("rst_adat", Adat, 0);
    chk("rst_bdat", Bdat, 0);
    chk("rst_res", res_data, 0);
    chk("rst_flags", {res_zero, res_carry, res_ovf}, 0);
    rst = 1'b0;

    // T2 single req0
    req0 = 1; alu_op0 = 2'b01; fuc0 = 6'b100000; a0 = 4; b0 = 4;
    tick();
    chk("t2_grant0", grant0, 1);
    chk("t2_grant1", grant1, 0);
    chk("t2_busy", busy, 1);
    chk("t2_aluop", ALUop, 2'b01);
    chk("t2_fuc", Fuc, 6'b100000);
    chk("t2_adat", Adat, 4);
    chk("t2_bdat", Bdat, 4);
    tick(); tick();
    chk("t2_done_early", done0, 0);
    tick();
    chk("t2_done0", done0, 1);
    chk("t2_done1", done1, 0);
    chk("t2_grant_in_done", grant0, 1);
    chk("t2_res", res_data, 8);
    chk("t2_zero", res_zero, 0);
    req0 = 0;
    tick();
    chk("t2_idle_done", done0, 0);
    chk("t2_idle_busy", busy, 0);
    chk("t2_idle_grant", grant0, 0);
    chk("t2_idle_adat_hold", Adat, 4);
    chk("t2_idle_res_hold", res_data, 8);

    // T3 simultaneous requests after reset
    rst = 1; tick(); tick(); rst = 0;
    req0 = 1; req1 = 1; a0 = 10; b0 = 20; a1 = 100; b1 = 200;
    tick();
    chk("t3_first_grant0", grant0, 1);
    chk("t3_first_grant1", grant1, 0);
    chk("t3_first_adat", Adat, 10);
    wait_done(0, LAT, "t3_a");
    chk("t3_a_res", res_data, 30);
    req0 = 0;
    tick();
    chk("t3_gap_busy", busy, 0);
    chk("t3_gap_grant1", grant1, 0);
    tick();
    chk("t3_second_grant1", grant1, 1);
    chk("t3_second_grant0", grant0, 0);
    chk("t3_second_adat", Adat, 100);
    wait_done(1, LAT, "t3_b");
    chk("t3_b_done0", done0, 0);
    chk("t3_b_res", res_data, 300);
    req1 = 0;
    tick();
    req0 = 1; req1 = 1; a0 = 1; b0 = 2; a1 = 3; b1 = 4;
    tick();
    chk("t3_pair2_grant0", grant0, 1);
    chk("t3_pair2_grant1", grant1, 0);
    wait_done(0, LAT, "t3_c");
    chk("t3_c_res", res_data, 3);
    req0 = 0;
    tick(); tick();
    chk("t3_d_grant1", grant1, 1);
    wait_done(1, LAT, "t3_d");
    chk("t3_d_res", res_data, 7);
    req1 = 0;
    tick();

    // T4 carry / overflow via req1
    req1 = 1; a1 = 32'hFFFF_FFFF; b1 = 1;
    tick();
    chk("t4_grant1", grant1, 1);
    wait_done(1, LAT, "t4_a");
    chk("t4_a_res", res_data, 0);
    chk("t4_a_zero", res_zero, 1);
    chk("t4_a_carry", res_carry, 1);
    chk("t4_a_ovf", res_ovf, 0);
    req1 = 0;
    tick();
    req1 = 1; a1 = 32'h7FFF_FFFF; b1 = 1;
    tick();
    wait_done(1, LAT, "t4_b");
    chk("t4_b_res", res_data, 32'h8000_0000);
    chk("t4_b_zero", res_zero, 0);
    chk("t4_b_carry", res_carry, 0);
    chk("t4_b_ovf", res_ovf, 1);
    req1 = 0;
    tick();

    // T5 reset in the middle of EXEC
    req0 = 1; a0 = 5; b0 = 6;
    tick();
    chk("t5_grant0", grant0, 1);
    tick();
    chk("t5_mid_done", done0, 0);
    rst = 1;
    tick();
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_grant0", grant0, 0);
    chk("t5_rst_done0", done0, 0);
    chk("t5_rst_res", res_data, 0);
    chk("t5_rst_ovf", res_ovf, 0);
    chk("t5_rst_adat", Adat, 0);
    rst = 0;
    tick();
    chk("t5_regrant0", grant0, 1);
    chk("t5_regrant_adat", Adat, 5);
    wait_done(0, LAT, "t5");
    chk("t5_res", res_data, 11);
    req0 = 0;
    tick();

    // T6 operand change after grant is ignored
    req0 = 1; a0 = 7; b0 = 8;
    tick();
    chk("t6_adat", Adat, 7);
    a0 = 1000;
    tick();
    chk("t6_adat_held", Adat, 7);
    wait_done(0, LAT - 1, "t6");
    chk("t6_res", res_data, 15);
    req0 = 0;
    tick();
    chk("t6_idle_adat", Adat, 7);
    chk("t6_idle_busy", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
